led_matrix_scan_ctrl: RTL
=========================

Name: led_matrix_scan_ctrl

Overview:
Parametrised multiplexed LED-matrix column scanner, successor to the fixed 8x8 scanner. Drives one active column at a time from a double-buffered frame, with a blanking gap between columns to suppress ghosting and per-frame PWM brightness. Sits between the frame producer (pattern/animation logic) and the matrix pins; frames are accepted through a valid/ready handshake and swapped in only at frame boundaries, so partial frames are never shown.

Parameters:
P_COLS, 8, number of matrix columns (scan lines), >=2
P_ROWS, 8, number of matrix rows (data lines), >=1
P_DWELL_CYCLES, 256, aclk cycles of the DRIVE phase per column, >= 2**P_BRIGHT_W
P_BLANK_CYCLES, 4, aclk cycles of the all-off BLANK phase before each column, >=1
P_BRIGHT_W, 4, brightness code width
P_COL_ACTIVE_LOW, 1, 1: the selected column is driven 0 and the others 1; 0: inverted
P_ROW_ACTIVE_HIGH, 1, 1: a lit row is driven 1; 0: inverted

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
i_frame_data  in  P_ROWS*P_COLS  pixel (r,c) = bit r*P_COLS+c, 1 = lit
i_frame_valid  in  1  producer offers i_frame_data
o_frame_ready  out  1  pending buffer empty; transfer when valid&&ready
i_enable  in  1  scanning enabled
i_brightness  in  P_BRIGHT_W  brightness code, sampled at frame start
o_col  out  P_COLS  column drive lines
o_row  out  P_ROWS  row drive lines
o_col_idx  out  clog2(P_COLS)  index of the current column
o_frame_start  out  1  one-cycle pulse on the first BLANK cycle of column 0

Behaviour:
- Reset (async, areset=1): state IDLE; active and pending buffers cleared to 0; pending_full=0; o_frame_ready=1; o_col all inactive; o_row all unlit; o_col_idx=0; o_frame_start=0; brightness register=0.
- All outputs are registered and change on the same edge as the state register.
- FSM states: IDLE, BLANK, DRIVE.
  IDLE: outputs inactive; if i_enable=1 -> BLANK, col_idx=0, frame boundary.
  BLANK: all columns inactive, all rows unlit, for P_BLANK_CYCLES cycles -> DRIVE.
  DRIVE: column col_idx active for P_DWELL_CYCLES cycles; then col_idx increments (wrapping from P_COLS-1 to 0) -> BLANK. Wrap to 0 is a frame boundary.
  In any state, i_enable=0 -> IDLE on the next edge. Outputs go inactive and the counters and col_idx clear. Pending is kept.
- Frame period = P_COLS*(P_BLANK_CYCLES+P_DWELL_CYCLES) cycles.
- Frame boundary (entry into BLANK with col_idx=0):
  - o_frame_start=1 for that cycle.
  - If pending_full, active<=pending and pending_full<=0.
  - brightness register <= i_brightness.
- Row data during DRIVE: o_row[r] = lit-level of active[r*P_COLS+col_idx] when dwell_cnt < on_cycles; otherwise unlit.
- on_cycles:
  - = P_DWELL_CYCLES when the brightness code is all-ones.
  - Otherwise = (code*P_DWELL_CYCLES)>>P_BRIGHT_W, computed with width wide enough that there is no overflow.
  - Code 0 = dark.
- Handshake:
  - A transfer on valid&&ready loads pending and sets pending_full; o_frame_ready falls on the next edge.
  - ready rises again on the edge after the swap.
  - i_frame_data is ignored when there is no transfer.
  - Transfer and boundary in the same cycle: the swap sees pending_full=0, so nothing is swapped. The new frame lands in pending and is shown from the next boundary.
  - Several frames offered within one frame period: the first is accepted and the producer stalls on the rest.
- Reset mid-frame: immediate inactive outputs; the pending frame is lost.

Decomposition:
- Shared include led_matrix_pkg: state encodings (IDLE/BLANK/DRIVE) and the on_cycles width helper.
- One sub-module, led_frame_dbuf: pending/active registers, pending_full, o_frame_ready, swap on boundary strobe.
- The FSM, counters and PWM compare stay in the top.

Test Plan:
Bench parameters: P_COLS=8, P_ROWS=8, P_DWELL_CYCLES=16, P_BLANK_CYCLES=2, P_BRIGHT_W=4.
1. Reset then i_enable=1, brightness=15, frame=64'h0 -> o_frame_start pulses every 144 cycles; o_col walks 8'hFE,FD,...,7F, each for 16 cycles with 2 cycles of 8'hFF between; o_row=0 throughout.
2. Load diagonal frame 64'h8040201008040201 -> while col c is active, o_row=(1<<c) for all 16 DRIVE cycles; o_row=0 in every BLANK cycle.
3. Brightness=4 with frame all-ones -> o_row=8'hFF for exactly 4 cycles, then 8'h00 for 12, in each column. Brightness=0 -> o_row stays 0. A brightness change mid-frame takes effect only at the next o_frame_start.
4. Handshake: offer frame A mid-frame -> accepted and ready falls. Offer B next -> stalled until the cycle after the boundary. A is displayed from the boundary; B is displayed from the following boundary. Valid coincident with the boundary cycle -> the frame is shown one frame later.
5. Deassert i_enable mid-DRIVE of col 5 -> next edge o_col=8'hFF, o_row=0, o_col_idx=0. Re-enable -> o_frame_start fires and the scan restarts at col 0.
6. Assert areset mid-frame with pending_full=1 -> outputs immediately inactive, o_frame_ready=1. After release and enable, the frame is blank (the pending frame was discarded).

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types for the LED matrix column scanner.
// FSM state encoding and the PWM on-time width helper.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_e;

  // Wide enough to hold code*dwell before the shift, so nothing overflows
  function automatic int on_cycles_w(int dwell, int bw);
    return $clog2(dwell + 1) + bw;
  endfunction

endpackage

// File: rtl/led_frame_dbuf.sv
// Double-buffered frame store: producer fills pending,
// the scanner swaps pending into active only at frame boundaries.
module led_frame_dbuf #(
  parameter int P_BITS = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [P_BITS-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              swap_i,
  output logic [P_BITS-1:0] active_o
);

  logic [P_BITS-1:0] pend_q, pend_d;
  logic [P_BITS-1:0] act_q, act_d;
  logic              full_q, full_d;
  logic              xfer, swap;

  // xfer needs an empty pending slot and swap a full one, so they never collide
  assign xfer = valid_i && !full_q;
  assign swap = swap_i && full_q;

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    full_d = full_q;
    if (xfer) begin
      pend_d = data_i;
      full_d = 1'b1;
    end
    if (swap) begin
      act_d  = pend_q;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      act_q  <= '0;
      full_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      full_q <= full_d;
    end
  end

  assign ready_o  = !full_q;
  assign active_o = act_q;

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Multiplexed LED matrix column scanner with blanking gap
// and per-frame PWM brightness; all outputs registered.
module led_matrix_scan_ctrl #(
  parameter int P_COLS            = 8,
  parameter int P_ROWS            = 8,
  parameter int P_DWELL_CYCLES    = 256,
  parameter int P_BLANK_CYCLES    = 4,
  parameter int P_BRIGHT_W        = 4,
  parameter int P_COL_ACTIVE_LOW  = 1,
  parameter int P_ROW_ACTIVE_HIGH = 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [P_ROWS*P_COLS-1:0]   i_frame_data,
  input  logic                       i_frame_valid,
  output logic                       o_frame_ready,
  input  logic                       i_enable,
  input  logic [P_BRIGHT_W-1:0]      i_brightness,
  output logic [P_COLS-1:0]          o_col,
  output logic [P_ROWS-1:0]          o_row,
  output logic [$clog2(P_COLS)-1:0]  o_col_idx,
  output logic                       o_frame_start
);
  import led_matrix_pkg::*;

  localparam int CW   = $clog2(P_COLS);
  localparam int CMAX = (P_DWELL_CYCLES > P_BLANK_CYCLES) ?
                        P_DWELL_CYCLES : P_BLANK_CYCLES;
  localparam int NW   = $clog2(CMAX);
  localparam int OW   = on_cycles_w(P_DWELL_CYCLES, P_BRIGHT_W);
  localparam int KW   = (OW > NW) ? OW : NW;

  localparam logic [P_COLS-1:0] COL_OFF =
    (P_COL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [P_ROWS-1:0] ROW_OFF =
    (P_ROW_ACTIVE_HIGH != 0) ? '0 : '1;
  localparam logic [NW-1:0] BLANK_LAST = NW'(P_BLANK_CYCLES - 1);
  localparam logic [NW-1:0] DWELL_LAST = NW'(P_DWELL_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(P_COLS - 1);

  state_e                    state_q, state_d;
  logic [NW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             idx_q, idx_d;
  logic [P_COLS-1:0]         cdrv_q, cdrv_d;
  logic [P_ROWS-1:0]         row_q, row_d;
  logic                      fs_q;
  logic [P_BRIGHT_W-1:0]     bright_q, bright_d;
  logic                      boundary;
  logic [OW-1:0]             on_cycles;
  logic                      lit_win;
  logic [P_ROWS*P_COLS-1:0]  active;

  led_frame_dbuf #(
    .P_BITS (P_ROWS*P_COLS)
  ) u_dbuf (
    .clk_i    (aclk),
    .rst_i    (areset),
    .data_i   (i_frame_data),
    .valid_i  (i_frame_valid),
    .ready_o  (o_frame_ready),
    .swap_i   (boundary),
    .active_o (active)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = '0;
          boundary = 1'b1;
        end
        (state_q == ST_BLANK): begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
        (state_q == ST_DRIVE): begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == COL_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // The all-ones code means always on; otherwise a fraction of the dwell
  always_comb begin
    if (&bright_q)
      on_cycles = OW'(P_DWELL_CYCLES);
    else
      on_cycles = (OW'(bright_q) * OW'(P_DWELL_CYCLES)) >> P_BRIGHT_W;
  end

  assign lit_win  = KW'(cnt_d) < KW'(on_cycles);
  assign bright_d = boundary ? i_brightness : bright_q;

  always_comb begin
    cdrv_d = COL_OFF;
    row_d  = ROW_OFF;
    if (state_d == ST_DRIVE) begin
      cdrv_d = COL_OFF ^ (P_COLS'(1) << idx_d);
      if (lit_win) begin
        for (int r = 0; r < P_ROWS; r++)
          row_d[r] = ROW_OFF[r] ^ active[r*P_COLS + int'(idx_d)];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      cdrv_q   <= COL_OFF;
      row_q    <= ROW_OFF;
      fs_q     <= 1'b0;
      bright_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cdrv_q   <= cdrv_d;
      row_q    <= row_d;
      fs_q     <= boundary;
      bright_q <= bright_d;
    end
  end

  assign o_col         = cdrv_q;
  assign o_row         = row_q;
  assign o_col_idx     = idx_q;
  assign o_frame_start = fs_q;

endmodule
